// File: rtl/cam_capture_ctrl_if.sv
// Pixel stream from the capture sequencer to the frame-buffer writer.
// A beat transfers on a rising edge where pix_valid and pix_ready are both 1; while
// pix_valid=1 and pix_ready=0 the source holds pix_data/pix_addr unchanged.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              pix_valid;
  logic              pix_ready;
  logic [15:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;

  modport master (output pix_valid, output pix_data, output pix_addr, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_addr, output pix_ready);
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture sequencer: arms on start/shutter, syncs to vsync, packs byte
// pairs into RGB565 pixels with linear framebuffer addresses, reports status.
module cam_capture_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        cam_data,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic              cam_shutter,
  input  logic              start,
  input  logic              continuous,
  input  logic              shutter_en,
  input  logic              abort,
  input  logic              clr_err,
  cam_capture_ctrl_if.master pix,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              ovf_err,
  output logic              size_err,
  output logic [1:0]        state_dbg
);
  // Counters carry headroom above the nominal geometry so oversize lines/frames
  // are detected rather than wrapping back into range.
  localparam int COL_W  = $clog2(H_PIXELS) + 2;
  localparam int LINE_W = $clog2(V_LINES) + 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3} state_t;
  state_t state, state_next;

  logic [7:0]        data_r, hi_byte;
  logic              href_r, href_p, vsync_r, vsync_p, shut_r, shut_p;
  logic              phase;
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [ADDR_W-1:0] addr_calc;
  logic              vsync_fall, vsync_rise, href_fall, shut_rise, arm_req;
  logic              capturing, pix_done, in_range, stalled, pix_load, frame_end;
  logic              line_bad, set_size, set_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= '0;
      href_r  <= 1'b0;
      href_p  <= 1'b0;
      vsync_r <= 1'b0;
      vsync_p <= 1'b0;
      shut_r  <= 1'b0;
      shut_p  <= 1'b0;
    end else begin
      data_r  <= cam_data;
      href_r  <= cam_href;
      href_p  <= href_r;
      vsync_r <= cam_vsync;
      vsync_p <= vsync_r;
      shut_r  <= cam_shutter;
      shut_p  <= shut_r;
    end
  end

  assign vsync_fall = vsync_p & ~vsync_r;
  assign vsync_rise = ~vsync_p & vsync_r;
  assign href_fall  = href_p & ~href_r;
  assign shut_rise  = ~shut_p & shut_r;
  assign arm_req    = start | (shutter_en & shut_rise);

  assign capturing = (state == S_CAPTURE);
  assign pix_done  = capturing & href_r & phase;
  assign in_range  = (col_cnt < COL_W'(H_PIXELS)) && (line_cnt < LINE_W'(V_LINES));
  assign stalled   = pix.pix_valid & ~pix.pix_ready;
  assign pix_load  = pix_done & in_range & ~stalled & ~abort;
  assign frame_end = capturing & vsync_rise & ~abort;
  assign line_bad  = capturing & href_fall & (col_cnt != '0) & (col_cnt != COL_W'(H_PIXELS));
  assign set_size  = (pix_done & ~in_range) | line_bad | (frame_end & (line_cnt != LINE_W'(V_LINES)));
  assign set_ovf   = pix_done & in_range & stalled;
  assign addr_calc = ADDR_W'(32'(line_cnt) * 32'(H_PIXELS) + 32'(col_cnt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (arm_req) state_next = S_ARMED;
      S_ARMED:   if (vsync_fall) state_next = S_CAPTURE;
      S_CAPTURE: if (vsync_rise) state_next = S_DONE;
      S_DONE:    state_next = continuous ? S_ARMED : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_comb begin
    busy      = (state == S_ARMED) || (state == S_CAPTURE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Byte phase and geometry counters; the column still advances for dropped pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= 1'b0;
      hi_byte  <= '0;
      col_cnt  <= '0;
      line_cnt <= '0;
    end else if (state == S_ARMED && vsync_fall) begin
      phase    <= 1'b0;
      col_cnt  <= '0;
      line_cnt <= '0;
    end else if (capturing) begin
      if (href_r) begin
        phase <= ~phase;
        if (!phase) hi_byte <= data_r;
        else if (col_cnt != '1) col_cnt <= col_cnt + 1'b1;
      end else begin
        phase <= 1'b0;
        if (href_fall && col_cnt != '0) begin
          col_cnt <= '0;
          if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.pix_addr  <= '0;
    end else if (abort) begin
      pix.pix_valid <= 1'b0;
    end else if (pix_load) begin
      pix.pix_valid <= 1'b1;
      pix.pix_data  <= {hi_byte, data_r};
      pix.pix_addr  <= addr_calc;
    end else if (pix.pix_valid && pix.pix_ready) begin
      pix.pix_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      ovf_err   <= 1'b0;
      size_err  <= 1'b0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      ovf_err  <= set_ovf | (ovf_err & ~clr_err);
      size_err <= set_size | (size_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl with a small 4x2 frame geometry and a 3-bit frame counter.
module tb_cam_capture_ctrl;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 4;
  localparam int CW = 3;
  localparam int W  = AW + 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    cam_data = '0;
  logic          cam_href = 1'b0, cam_vsync = 1'b0, cam_shutter = 1'b0;
  logic          start = 1'b0, continuous = 1'b0, shutter_en = 1'b0, abort = 1'b0, clr_err = 1'b0;
  logic          busy, done, ovf_err, size_err;
  logic [CW-1:0] frame_cnt;
  logic [1:0]    state_dbg;

  cam_capture_ctrl_if #(.ADDR_W(AW)) pix ();

  cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .cam_data(cam_data), .cam_href(cam_href),
    .cam_vsync(cam_vsync), .cam_shutter(cam_shutter), .start(start),
    .continuous(continuous), .shutter_en(shutter_en), .abort(abort), .clr_err(clr_err),
    .pix(pix), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .ovf_err(ovf_err), .size_err(size_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0, n_miss = 0, done_cnt = 0, exp_done = 0, exp_frames = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] held = '0, got = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // monitor: pops on every accepted beat, checks hold stability during stalls
  always @(negedge clk) begin
    if (!reset_n || !pix.pix_valid) stall_prev = 1'b0;
    else begin
      if (stall_prev) check("hold_stable", 32'({pix.pix_addr, pix.pix_data}), 32'(held));
      if (pix.pix_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pixel: got addr %0d data %h, expected none", pix.pix_addr, pix.pix_data);
        end else begin
          got = exp_q.pop_front();
          check("pixel", 32'({pix.pix_addr, pix.pix_data}), 32'(got));
        end
      end
      stall_prev = !pix.pix_ready;
      held = {pix.pix_addr, pix.pix_data};
    end
    if (reset_n && done) done_cnt++;
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; cycle(); clr_err = 1'b0; cycle();
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1; repeat (3) cycle();
    cam_vsync = 1'b0; repeat (4) cycle();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1; repeat (4) cycle();
    exp_done++;
    exp_frames++;
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1; cam_data = base + 8'(i); cycle();
    end
    cam_href = 1'b0; cam_data = '0; repeat (4) cycle();
  endtask

  task automatic push_pix(input int addr, input logic [7:0] hb);
    logic [7:0] lb;
    lb = hb + 8'd1;
    exp_q.push_back({AW'(addr), hb, lb});
  endtask

  task automatic push_line(input int line, input int npix, input logic [7:0] base);
    for (int k = 0; k < npix; k++) push_pix(line * H + k, base + 8'(2 * k));
  endtask

  task automatic full_frame(input logic [7:0] base);
    push_line(0, 4, base);
    push_line(1, 4, base + 8'd8);
    frame_begin(); send_line(8, base); send_line(8, base + 8'd8); frame_end();
  endtask

  task automatic check_frame_status(input string tag);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames % 8));
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    pix.pix_ready = 1'b1;
    #12;
    check("rst_valid", 32'(pix.pix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_errs", 32'({ovf_err, size_err}), 0);
    check("rst_state", 32'(state_dbg), 0);
    cycle(); reset_n = 1'b1; repeat (2) cycle();

    // full frame, no backpressure
    pulse_start(); cycle();
    check("armed_busy", 32'(busy), 1);
    check("armed_state", 32'(state_dbg), 1);
    full_frame(8'h00);
    cycle();
    check_frame_status("f1");
    check("f1_errs", 32'({ovf_err, size_err}), 0);
    check("f1_busy", 32'(busy), 0);

    // backpressure: first pixel held, next two dropped
    pix.pix_ready = 1'b0;
    push_pix(0, 8'h00);
    push_pix(3, 8'h06);
    push_line(1, 4, 8'h08);
    pulse_start();
    fork
      begin
        frame_begin(); send_line(8, 8'h00); send_line(8, 8'h08); frame_end();
      end
      begin
        int t;
        t = 0;
        while (!pix.pix_valid && t < 200) begin cycle(); t++; end
        check("stall_wait_timeout", 32'(t < 200), 1);
        repeat (4) @(posedge clk);
        #1;
        pix.pix_ready = 1'b1;
      end
    join
    cycle();
    check_frame_status("f2");
    check("f2_ovf", 32'(ovf_err), 1);
    check("f2_size", 32'(size_err), 0);
    pulse_clr();
    check("f2_ovf_clr", 32'(ovf_err), 0);

    // oversize line, then undersize frame
    push_line(0, 4, 8'h00);
    push_line(1, 4, 8'h10);
    pulse_start();
    frame_begin(); send_line(10, 8'h00);
    check("long_line_size", 32'(size_err), 1);
    send_line(8, 8'h10); frame_end(); cycle();
    check_frame_status("f3");
    pulse_clr();
    check("size_clr", 32'(size_err), 0);
    push_line(0, 4, 8'h20);
    pulse_start();
    frame_begin(); send_line(8, 8'h20);
    check("short_frame_pre", 32'(size_err), 0);
    frame_end(); cycle();
    check("short_frame_size", 32'(size_err), 1);
    check_frame_status("f4");
    pulse_clr();

    // continuous capture over three frames
    continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      full_frame(8'h30 + 8'(f * 16));
      check("cont_state_armed", 32'(state_dbg), 1);
      check_frame_status("cont");
    end
    continuous = 1'b0;
    abort = 1'b1; cycle(); abort = 1'b0; cycle();
    check("cont_abort_idle", 32'(state_dbg), 0);

    // shutter arming; start during capture is ignored; counter wraps
    cam_shutter = 1'b1; repeat (2) cycle(); cam_shutter = 1'b0; repeat (2) cycle();
    check("shutter_disabled", 32'(state_dbg), 0);
    shutter_en = 1'b1;
    cam_shutter = 1'b1; repeat (3) cycle(); cam_shutter = 1'b0; cycle();
    shutter_en = 1'b0;
    check("shutter_armed", 32'(state_dbg), 1);
    push_line(0, 4, 8'h60);
    push_line(1, 4, 8'h68);
    frame_begin();
    pulse_start(); cycle();
    check("start_in_capture", 32'(state_dbg), 2);
    send_line(8, 8'h60); send_line(8, 8'h68); frame_end(); cycle();
    check_frame_status("wrap");
    check("wrap_idle", 32'(state_dbg), 0);

    // abort mid-line while a pixel is held
    pix.pix_ready = 1'b0;
    pulse_start();
    frame_begin();
    for (int i = 0; i < 6; i++) begin
      cam_href = 1'b1; cam_data = 8'h40 + 8'(i);
      if (i == 5) abort = 1'b1;
      cycle();
      if (i == 4) check("abort_pre_valid", 32'(pix.pix_valid), 1);
    end
    abort = 1'b0;
    check("abort_valid", 32'(pix.pix_valid), 0);
    check("abort_state", 32'(state_dbg), 0);
    cam_href = 1'b0; pix.pix_ready = 1'b1; cycle();
    check("abort_ovf", 32'(ovf_err), 1);
    pulse_clr();

    // asynchronous reset mid-frame
    pix.pix_ready = 1'b0;
    pulse_start();
    frame_begin();
    for (int i = 0; i < 4; i++) begin
      cam_href = 1'b1; cam_data = 8'h50 + 8'(i); cycle();
    end
    cam_href = 1'b0; cycle();
    check("pre_rst_valid", 32'(pix.pix_valid), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_frames = 0;
    check("arst_valid", 32'(pix.pix_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_state", 32'(state_dbg), 0);
    check("arst_errs", 32'({ovf_err, size_err}), 0);
    check("arst_data", 32'({pix.pix_addr, pix.pix_data}), 0);
    pix.pix_ready = 1'b1;
    cycle(); reset_n = 1'b1; repeat (2) cycle();

    // normal capture after reset
    pulse_start();
    full_frame(8'h80);
    cycle();
    check_frame_status("post_rst");
    check("post_rst_errs", 32'({ovf_err, size_err}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-capture sequencer for the 8-bit parallel camera port (cam_data/cam_href/cam_vsync/cam_shutter) inside soc_system. It arms on a software start or a shutter press, then waits for a frame boundary. It packs byte pairs into RGB565 pixels, tags each with a linear framebuffer address, and hands them to the downstream frame-buffer writer over a valid/ready stream. Status (busy, done, frame count, error flags) goes to the HPS-facing CSR block.

Parameters:
H_PIXELS, 640, pixels per line accepted
V_LINES, 480, lines per frame accepted
ADDR_W, 19, pixel address width (must satisfy 2^ADDR_W >= H_PIXELS*V_LINES)
CNT_W, 16, frame counter width

Ports:
clk  in  1  camera pixel clock (pclk domain); all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cam_data  in  8  camera byte bus
cam_href  in  1  line valid, active high
cam_vsync  in  1  frame sync, active high during vertical blanking
cam_shutter  in  1  shutter button, synchronous, active high
start  in  1  one-cycle pulse: arm single capture
continuous  in  1  level: re-arm automatically after each frame
shutter_en  in  1  level: shutter rising edge acts as start
abort  in  1  one-cycle pulse: return to IDLE
clr_err  in  1  one-cycle pulse: clear sticky error flags
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  16  RGB565 pixel, first byte in [15:8]
pix_addr  out  ADDR_W  line*H_PIXELS + column
busy  out  1  high in ARMED or CAPTURE
done  out  1  one-cycle pulse at frame end
frame_cnt  out  CNT_W  completed frames, wraps
ovf_err  out  1  sticky: pixel dropped due to backpressure
size_err  out  1  sticky: frame geometry mismatch

Behaviour:
- Reset: FSM IDLE; all outputs 0; byte phase 0; line/column counters 0; input registers 0.
- Input stage: cam_data, cam_href, cam_vsync and cam_shutter are registered once. All edge detection uses the registered value against its previous copy.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED on start, or on shutter_en and a shutter rising edge.
  - ARMED -> CAPTURE on vsync falling edge. Clear line counter, column counter and byte phase.
  - CAPTURE -> DONE on vsync rising edge.
  - DONE lasts one cycle: done=1 and frame_cnt+1. Next state is ARMED if continuous=1, else IDLE.
- abort forces IDLE on the next edge from any state and clears pix_valid. abort wins over a simultaneous start or shutter.
- start or shutter while not IDLE is ignored.
- Byte packing, CAPTURE only, while registered href=1:
  - phase 0 latches the high byte; phase 1 completes the pixel.
  - Phase toggles every cycle with href=1 and resets to 0 when href=0.
  - An odd trailing byte is discarded.
- Column and line counting:
  - Each completed pixel increments the column.
  - A pixel with column >= H_PIXELS or line >= V_LINES is dropped (no output, no address) and sets size_err.
  - On href falling edge, if column != 0: line+1, column := 0. A line whose column != H_PIXELS sets size_err.
- Output register (single entry):
  - A completed, in-range pixel loads pix_data/pix_addr and sets pix_valid on the next edge. Latency is 2 clk edges from the edge sampling the low byte at the pins.
  - pix_valid falls after an edge with pix_valid&pix_ready, unless a new pixel loads on that same edge (then it stays 1 with new data).
  - A new pixel arriving while pix_valid=1 and pix_ready=0 is dropped and sets ovf_err; its address is still consumed (column advances). The held pixel is unchanged.
  - pix_data and pix_addr must stay stable while pix_valid=1 and pix_ready=0.
- Frame end: on the DONE entry edge, line != V_LINES sets size_err. A pending pixel is still delivered after DONE.
- Sticky flags: clr_err clears ovf_err and size_err. A simultaneous set wins over clear.
- frame_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- H_PIXELS=4, V_LINES=2, pix_ready=1; start, then a full frame with 2 lines × 8 bytes 0x00..0x0F -> pixels 0x0001,0x0203,...,0x0E0F at addr 0..7; done pulses once; frame_cnt=1; no errors; busy returns to 0.
- Same frame with pix_ready=0 held for 3 pixels -> first pixel held stable, next two dropped, ovf_err=1; clr_err -> ovf_err=0.
- Line of 10 bytes (5 pixels) with H_PIXELS=4 -> 5th pixel dropped, size_err=1; frame with 1 line -> size_err=1 at DONE.
- continuous=1 across 3 frames -> 3 done pulses, frame_cnt=3, FSM in ARMED after each frame; addresses restart at 0 each frame.
- shutter_en=1 with a shutter rising edge -> ARMED; shutter with shutter_en=0 -> stays IDLE; start during CAPTURE ignored.
- abort mid-line with pix_valid=1 -> IDLE and pix_valid=0 next edge; assert reset_n low mid-frame -> all outputs 0 immediately (asynchronous).
